// File: rtl/jtcop_mailbox.sv
// ============================================================================
// Module   : jtcop_mailbox
// Purpose  : Shared dual-port RAM mailbox between the main CPU and an MCU,
//            with per-channel main->MCU doorbells and one MCU->main doorbell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtcop_mailbox #(
  parameter int AW      = 11,
  parameter int CH      = 4,
  parameter int IRQ_LEN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic [7:0]    main_din,
  input  logic          main_cs,
  input  logic          main_wrn,
  output logic          main_irqn,
  input  logic [AW-1:0] mcu_addr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  input  logic          mcu_cs,
  input  logic          mcu_wrn,
  output logic          mcu_waitn,
  output logic [CH-1:0] mcu_irqn,
  output logic          mcu_irq_any
);

  localparam logic [AW-1:0] c_top      = {AW{1'b1}};
  localparam logic [AW-1:0] c_rev_addr = c_top - AW'(CH);
  localparam logic [7:0]    c_tmr_load = 8'(IRQ_LEN);

  logic [7:0] r_mem [0:(2**AW)-1];

  logic w_main_wr, w_main_rd;
  logic w_mcu_acc, w_mcu_wr, w_mcu_rd;
  logic w_collide;

  logic [CH-1:0]      r_pending, w_pending_nxt;
  logic [CH-1:0][7:0] r_timer,   w_timer_nxt;

  // The MCU side is frozen for the cycle after any main write
  assign w_main_wr = main_cs & ~main_wrn;
  assign w_main_rd = main_cs &  main_wrn;
  assign w_mcu_acc = mcu_cs & mcu_waitn;
  assign w_mcu_wr  = w_mcu_acc & ~mcu_wrn;
  assign w_mcu_rd  = w_mcu_acc &  mcu_wrn;
  assign w_collide = w_main_wr & w_mcu_wr & (main_addr == mcu_addr);

  // RAM contents survive reset, so this process has no reset branch
  always_ff @(posedge clk) begin
    if (w_mcu_wr && !w_collide) r_mem[mcu_addr] <= mcu_dout;
    if (w_main_wr)              r_mem[main_addr] <= main_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_din <= 8'h00;
      mcu_din  <= 8'h00;
    end else begin
      if (w_main_rd) main_din <= r_mem[main_addr];
      if (w_mcu_rd)  mcu_din  <= r_mem[mcu_addr];
    end
  end

  // Set has priority over ack and timeout; a re-trigger reloads the timer
  always_comb begin
    w_pending_nxt = r_pending;
    w_timer_nxt   = r_timer;
    for (int k = 0; k < CH; k++) begin
      if (w_main_wr && main_addr == (c_top - AW'(k))) begin
        w_pending_nxt[k] = 1'b1;
        w_timer_nxt[k]   = c_tmr_load;
      end else if (w_mcu_rd && mcu_addr == (c_top - AW'(k))) begin
        w_pending_nxt[k] = 1'b0;
        w_timer_nxt[k]   = 8'h00;
      end else if (r_timer[k] != 8'h00) begin
        w_timer_nxt[k] = r_timer[k] - 8'h01;
        if (r_timer[k] == 8'h01) w_pending_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_timer     <= '0;
      mcu_irqn    <= '1;
      mcu_irq_any <= 1'b0;
      mcu_waitn   <= 1'b1;
      main_irqn   <= 1'b1;
    end else begin
      r_pending   <= w_pending_nxt;
      r_timer     <= w_timer_nxt;
      mcu_irqn    <= ~w_pending_nxt;
      mcu_irq_any <= |w_pending_nxt;
      mcu_waitn   <= ~w_main_wr;
      if (w_mcu_wr && mcu_addr == c_rev_addr)
        main_irqn <= 1'b0;
      else if (w_main_rd && main_addr == c_rev_addr)
        main_irqn <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtcop_mailbox.sv
// ============================================================================
// Module   : tb_jtcop_mailbox
// Purpose  : Directed, table-driven check of jtcop_mailbox (IRQ_LEN 0 and 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtcop_mailbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] main_addr = '0;
  logic [7:0]  main_dout = '0;
  logic        main_cs   = 1'b0;
  logic        main_wrn  = 1'b1;
  logic [10:0] mcu_addr  = '0;
  logic [7:0]  mcu_dout  = '0;
  logic        mcu_cs    = 1'b0;
  logic        mcu_wrn   = 1'b1;

  logic [7:0] main_din0, mcu_din0, main_din8, mcu_din8;
  logic       main_irqn0, mcu_waitn0, any0, main_irqn8, mcu_waitn8, any8;
  logic [3:0] irqn0, irqn8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtcop_mailbox #(.AW(11), .CH(4), .IRQ_LEN(0)) dut0 (
    .clk(clk), .rst(rst),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din0),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_irqn(main_irqn0),
    .mcu_addr(mcu_addr), .mcu_dout(mcu_dout), .mcu_din(mcu_din0),
    .mcu_cs(mcu_cs), .mcu_wrn(mcu_wrn), .mcu_waitn(mcu_waitn0),
    .mcu_irqn(irqn0), .mcu_irq_any(any0)
  );

  jtcop_mailbox #(.AW(11), .CH(4), .IRQ_LEN(8)) dut8 (
    .clk(clk), .rst(rst),
    .main_addr(main_addr), .main_dout(main_dout), .main_din(main_din8),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_irqn(main_irqn8),
    .mcu_addr(mcu_addr), .mcu_dout(mcu_dout), .mcu_din(mcu_din8),
    .mcu_cs(mcu_cs), .mcu_wrn(mcu_wrn), .mcu_waitn(mcu_waitn8),
    .mcu_irqn(irqn8), .mcu_irq_any(any8)
  );

  typedef struct {
    logic        mcs;  logic mwrn; logic [10:0] maddr; logic [7:0] mdo;
    logic        ccs;  logic cwrn; logic [10:0] caddr; logic [7:0] cdo;
    logic        chkm; logic [7:0] e_mdin;
    logic        chkc; logic [7:0] e_cdin;
    logic [3:0]  e_irqn; logic e_mirqn; logic e_waitn;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
  task automatic apply(input logic mcs, input logic mwrn, input logic [10:0] maddr,
                       input logic [7:0] mdo, input logic ccs, input logic cwrn,
                       input logic [10:0] caddr, input logic [7:0] cdo);
    @(negedge clk);
    main_cs = mcs; main_wrn = mwrn; main_addr = maddr; main_dout = mdo;
    mcu_cs  = ccs; mcu_wrn  = cwrn; mcu_addr  = caddr; mcu_dout  = cdo;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b1, 11'h0, 8'h0);
  endtask

  task automatic pulse(input bit retrig, output int cnt);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 0 || (retrig && i == 5))
        apply(1'b1, 1'b0, 11'h7FF, 8'h0F, 1'b0, 1'b1, 11'h0, 8'h0);
      else
        idle();
      if (irqn8[0] == 1'b0) cnt++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " irqn0"},      {4'h0, irqn0},  8'h0F);
    chk({tag, " any0"},       {7'h0, any0},   8'h00);
    chk({tag, " main_irqn0"}, {7'h0, main_irqn0}, 8'h01);
    chk({tag, " waitn0"},     {7'h0, mcu_waitn0}, 8'h01);
    chk({tag, " main_din0"},  main_din0, 8'h00);
    chk({tag, " mcu_din0"},   mcu_din0,  8'h00);
    chk({tag, " irqn8"},      {4'h0, irqn8},  8'h0F);
    chk({tag, " main_irqn8"}, {7'h0, main_irqn8}, 8'h01);
  endtask

  initial begin
    int cnt;

    //        mcs mwrn maddr   mdo    ccs cwrn caddr   cdo    chkm em     chkc ec     irqn  mirqn waitn
    vecs[0]  = '{1, 0, 11'h010, 8'h5A, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 1, 0};
    vecs[1]  = '{0, 1, 11'h000, 8'h00, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 1, 1};
    vecs[2]  = '{0, 1, 11'h000, 8'h00, 1, 1, 11'h010, 8'h00, 0, 8'h00, 1, 8'h5A, 4'hF, 1, 1};
    vecs[3]  = '{0, 1, 11'h000, 8'h00, 1, 0, 11'h020, 8'hC3, 0, 8'h00, 0, 8'h00, 4'hF, 1, 1};
    vecs[4]  = '{0, 1, 11'h000, 8'h00, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 1, 1};
    vecs[5]  = '{1, 1, 11'h020, 8'h00, 0, 1, 11'h000, 8'h00, 1, 8'hC3, 0, 8'h00, 4'hF, 1, 1};
    vecs[6]  = '{1, 0, 11'h7FE, 8'h77, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hD, 1, 0};
    vecs[7]  = '{0, 1, 11'h000, 8'h00, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hD, 1, 1};
    vecs[8]  = '{0, 1, 11'h000, 8'h00, 1, 1, 11'h7FE, 8'h00, 0, 8'h00, 1, 8'h77, 4'hF, 1, 1};
    vecs[9]  = '{0, 1, 11'h000, 8'h00, 1, 0, 11'h7FB, 8'h33, 0, 8'h00, 0, 8'h00, 4'hF, 0, 1};
    vecs[10] = '{0, 1, 11'h000, 8'h00, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 0, 1};
    vecs[11] = '{1, 1, 11'h7FB, 8'h00, 0, 1, 11'h000, 8'h00, 1, 8'h33, 0, 8'h00, 4'hF, 1, 1};
    vecs[12] = '{1, 0, 11'h100, 8'hAA, 1, 0, 11'h100, 8'h55, 0, 8'h00, 0, 8'h00, 4'hF, 1, 0};
    vecs[13] = '{0, 1, 11'h000, 8'h00, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 1, 1};
    vecs[14] = '{1, 1, 11'h100, 8'h00, 0, 1, 11'h000, 8'h00, 1, 8'hAA, 0, 8'h00, 4'hF, 1, 1};
    vecs[15] = '{0, 1, 11'h000, 8'h00, 1, 1, 11'h100, 8'h00, 0, 8'h00, 1, 8'hAA, 4'hF, 1, 1};
    vecs[16] = '{1, 0, 11'h200, 8'h11, 0, 1, 11'h000, 8'h00, 0, 8'h00, 0, 8'h00, 4'hF, 1, 0};
    vecs[17] = '{0, 1, 11'h000, 8'h00, 1, 1, 11'h200, 8'h00, 0, 8'h00, 1, 8'hAA, 4'hF, 1, 1};
    vecs[18] = '{0, 1, 11'h000, 8'h00, 1, 1, 11'h200, 8'h00, 0, 8'h00, 1, 8'h11, 4'hF, 1, 1};
    vecs[19] = '{1, 1, 11'h7FB, 8'h00, 1, 0, 11'h7FB, 8'h44, 0, 8'h00, 0, 8'h00, 4'hF, 0, 1};
    vecs[20] = '{1, 1, 11'h7FB, 8'h00, 0, 1, 11'h000, 8'h00, 1, 8'h44, 0, 8'h00, 4'hF, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].mcs, vecs[i].mwrn, vecs[i].maddr, vecs[i].mdo,
            vecs[i].ccs, vecs[i].cwrn, vecs[i].caddr, vecs[i].cdo);
      chk($sformatf("v%0d irqn", i),      {4'h0, irqn0}, {4'h0, vecs[i].e_irqn});
      chk($sformatf("v%0d irq_any", i),   {7'h0, any0},  {7'h0, (vecs[i].e_irqn != 4'hF)});
      chk($sformatf("v%0d main_irqn", i), {7'h0, main_irqn0}, {7'h0, vecs[i].e_mirqn});
      chk($sformatf("v%0d waitn", i),     {7'h0, mcu_waitn0}, {7'h0, vecs[i].e_waitn});
      if (vecs[i].chkm) chk($sformatf("v%0d main_din", i), main_din0, vecs[i].e_mdin);
      if (vecs[i].chkc) chk($sformatf("v%0d mcu_din", i),  mcu_din0,  vecs[i].e_cdin);
    end

    // Ack-only channel holds for 100 cycles, then clears on MCU read
    apply(1'b1, 1'b0, 11'h7FE, 8'h5C, 1'b0, 1'b1, 11'h0, 8'h0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (irqn0 == 4'hD) cnt++;
    end
    chk("hold100 cycles", cnt[7:0], 8'd100);
    apply(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'h7FE, 8'h0);
    chk("ack irqn", {4'h0, irqn0}, 8'h0F);
    chk("ack data", mcu_din0, 8'h5C);

    // Timed auto-clear and re-trigger on the IRQ_LEN=8 instance
    pulse(1'b0, cnt);
    chk("pulse len", cnt[7:0], 8'd8);
    pulse(1'b1, cnt);
    chk("retrig len", cnt[7:0], 8'd13);
    chk("no timeout irqn0", {4'h0, irqn0}, 8'h0E);
    apply(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'h7FF, 8'h0);
    chk("ack ch0 irqn0", {4'h0, irqn0}, 8'h0F);
    chk("ack ch0 data", mcu_din0, 8'h0F);

    // Asynchronous reset with flags raised; RAM must survive it
    apply(1'b1, 1'b0, 11'h7FF, 8'hE1, 1'b0, 1'b1, 11'h0, 8'h0);
    apply(1'b1, 1'b0, 11'h7FE, 8'hE2, 1'b0, 1'b1, 11'h0, 8'h0);
    apply(1'b1, 1'b0, 11'h7FC, 8'hE4, 1'b0, 1'b1, 11'h0, 8'h0);
    idle();
    apply(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b0, 11'h7FB, 8'h66);
    chk("pre-rst irqn", {4'h0, irqn0}, 8'h04);
    chk("pre-rst main_irqn", {7'h0, main_irqn0}, 8'h00);
    chk("pre-rst any", {7'h0, any0}, 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("async rst");
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'h7FB, 8'h0);
    chk("post-rst mcu rd", mcu_din0, 8'h66);
    apply(1'b1, 1'b1, 11'h7FE, 8'h0, 1'b0, 1'b1, 11'h0, 8'h0);
    chk("post-rst main rd 7FE", main_din0, 8'hE2);
    apply(1'b1, 1'b1, 11'h100, 8'h0, 1'b0, 1'b1, 11'h0, 8'h0);
    chk("post-rst main rd 100", main_din0, 8'hAA);
    chk("post-rst irqn", {4'h0, irqn0}, 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
